mp_add_seq: RTL and testbench
=============================

# mp_add_seq

Word-serial multi-precision add sequencer that sits directly upstream of the combinational `adder` and also consumes its result. It accepts NUM_WORDS operand word pairs per operation, least-significant first. For each word it drives the adder's A/B/CI inputs, chains CO into the next word's CI through a carry register, and streams the registered sums out with valid/ready handshakes. This lets a DATA_WIDTH adder perform NUM_WORDS*DATA_WIDTH-bit additions at one word per cycle.

## Interface
- DATA_WIDTH, 32, word width; must match the attached adder's DATA_WIDTH
- NUM_WORDS, 4, words per operand (>= 1); counter width is $clog2(NUM_WORDS), minimum 1
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  operand word pair present
- IN_READY  out  1  sequencer can accept a word
- IN_A  in  DATA_WIDTH  operand A word
- IN_B  in  DATA_WIDTH  operand B word
- IN_CI  in  1  operation carry-in; sampled only with word 0
- OUT_VALID  out  1  registered sum word present
- OUT_READY  in  1  consumer accepts sum word
- OUT_SUM  out  DATA_WIDTH  sum word
- OUT_LAST  out  1  OUT_SUM is word NUM_WORDS-1
- OUT_CO  out  1  final carry-out; meaningful only with OUT_LAST, else 0
- ADD_A  out  DATA_WIDTH  to adder A (= IN_A, combinational)
- ADD_B  out  DATA_WIDTH  to adder B (= IN_B, combinational)
- ADD_CI  out  1  to adder CI
- ADD_O  in  DATA_WIDTH  from adder O
- ADD_CO  in  1  from adder CO

## Operation
- States: IDLE (word_cnt==0, next word is word 0) and BUSY (0 < word_cnt < NUM_WORDS). The state is derived from word_cnt.
- ADD_CI = IN_CI in IDLE, carry_reg in BUSY.
- One-deep output register: IN_READY = !OUT_VALID || OUT_READY.
- Accept occurs when IN_VALID && IN_READY. On accept:
  - OUT_SUM <= ADD_O; carry_reg <= ADD_CO; OUT_VALID <= 1.
  - OUT_LAST <= (word_cnt == NUM_WORDS-1); OUT_CO <= ADD_CO if last, else 0.
  - word_cnt increments; it wraps to 0 after the last word, returning to IDLE.
- No accept but OUT_READY && OUT_VALID: OUT_VALID <= 0. OUT_SUM, OUT_LAST and OUT_CO hold their values.
- Simultaneous drain and accept in the same cycle: the new word replaces the old. OUT_VALID stays 1 and no bubble is inserted.
- Carry never leaks between operations: word 0 always uses IN_CI.
- NUM_WORDS==1: every word is word 0 and last, and OUT_CO = ADD_CO of that word.
- While OUT_VALID && !OUT_READY: IN_READY=0, and OUT_SUM/OUT_LAST/OUT_CO stay stable.

## Timing
- Reset (RST_N low, asynchronous): OUT_VALID=0, OUT_SUM=0, OUT_LAST=0, OUT_CO=0, carry_reg=0, word_cnt=0. IN_READY=1 follows combinationally.
- Reset mid-operation discards the partial operation. The first word accepted after release is word 0.
- Latency: an accepted word appears on OUT_SUM with OUT_VALID=1 on the next rising edge.
- Throughput: one word per cycle while OUT_READY=1. One N-word operation takes N cycles.
- ADD_* paths are combinational through the adder. The critical path is IN_A -> adder -> OUT_SUM register.
- IN_A/IN_B/IN_CI need only be stable while IN_VALID is high and IN_READY is high at the edge.

## Test plan
- Reset check: hold RST_N=0 with random inputs -> OUT_VALID=0, OUT_SUM=0, OUT_LAST=0, OUT_CO=0, IN_READY=1. Release and send word 0 with A=34, B=19, IN_CI=1 -> OUT_SUM=54 next cycle.
- 128-bit carry ripple (DATA_WIDTH=32, NUM_WORDS=4): A=4×0xFFFFFFFF, B={1,0,0,0}, IN_CI=0, OUT_READY=1 -> sums 0,0,0,0; OUT_LAST on word 3 only; OUT_CO=1 on word 3.
- Backpressure: OUT_READY=0 for 3 cycles after word 1 -> IN_READY=0 and OUT_SUM frozen. Release -> all 4 words delivered in order with correct carries, none dropped or duplicated.
- Back-to-back operations: A=4×0xFFFFFFFF, B=4×0 with IN_CI=1, then A=B=4×0 with IN_CI=0, over 8 consecutive cycles -> first result 0,0,0,0 with OUT_CO=1; second result 0,0,0,0 with OUT_CO=0 (no carry leak).
- Reset mid-operation: assert RST_N after 2 words of an operation, then send 4 fresh words -> word 0 uses IN_CI, and OUT_LAST appears on the 4th post-reset word.
- Drain/accept same cycle: OUT_VALID=1, OUT_READY=1, IN_VALID=1 -> OUT_VALID stays 1 and OUT_SUM updates to the new word with no idle cycle.

Source files
------------

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add sequencer: feeds an external combinational adder
// one word pair per cycle, chains its carry-out, and registers the sum stream.
module mp_add_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_ci,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_sum,
   output logic                  out_last,
   output logic                  out_co,
   output logic [DATA_WIDTH-1:0] add_a,
   output logic [DATA_WIDTH-1:0] add_b,
   output logic                  add_ci,
   input  logic [DATA_WIDTH-1:0] add_o,
   input  logic                  add_co
);

   localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] word_cnt_reg;
   logic [CNT_W-1:0] word_cnt_next;
   logic             carry_reg;
   logic             accept;
   logic             is_last;

   assign add_a = in_a;
   assign add_b = in_b;

   // State is a pure function of the word counter; word 0 always takes the external carry-in.
   always_comb begin
      state         = IDLE;
      add_ci        = in_ci;
      in_ready      = !out_valid || out_ready;
      accept        = 1'b0;
      is_last       = 1'b0;
      word_cnt_next = word_cnt_reg;
      if (word_cnt_reg != '0) begin
         state = BUSY;
      end
      if (state == BUSY) begin
         add_ci = carry_reg;
      end
      accept  = in_valid && in_ready;
      is_last = (word_cnt_reg == LAST_CNT);
      if (accept) begin
         word_cnt_next = is_last ? '0 : word_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_reg <= '0;
         carry_reg    <= 1'b0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_last     <= 1'b0;
         out_co       <= 1'b0;
      end else begin
         word_cnt_reg <= word_cnt_next;
         if (accept) begin
            // A new word overwrites the draining one, so no bubble appears.
            out_sum   <= add_o;
            carry_reg <= add_co;
            out_valid <= 1'b1;
            out_last  <= is_last;
            out_co    <= is_last ? add_co : 1'b0;
         end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with a behavioural 32-bit adder attached to the ADD_* ports.
module tb_mp_add_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_ci;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_last;
   logic        out_co;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_ci;
   logic [31:0] add_o;
   logic        add_co;

   int checks;
   int failures;

   mp_add_seq #(.DATA_WIDTH(32), .NUM_WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_last(out_last), .out_co(out_co),
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
      .add_o(add_o), .add_co(add_co)
   );

   assign {add_co, add_o} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word with the consumer ready, then check the registered result one edge later.
   task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] es, input logic el, input logic ec);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_ci     = ci;
      step();
      chk($sformatf("%s_valid", tag), {31'd0, out_valid}, 32'd1);
      chk($sformatf("%s_sum", tag), out_sum, es);
      chk($sformatf("%s_last", tag), {31'd0, out_last}, {31'd0, el});
      chk($sformatf("%s_co", tag), {31'd0, out_co}, {31'd0, ec});
      $display("xfer %s a=%08h b=%08h ci=%0d -> sum=%08h last=%0d co=%0d",
               tag, a, b, ci, out_sum, out_last, out_co);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_ci     = 1'b0;
      out_ready = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'($urandom);
         in_a      = $urandom;
         in_b      = $urandom;
         in_ci     = 1'($urandom);
         out_ready = 1'($urandom);
         step();
         chk("rst_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_sum", out_sum, 32'd0);
         chk("rst_last", {31'd0, out_last}, 32'd0);
         chk("rst_co", {31'd0, out_co}, 32'd0);
         chk("rst_ready", {31'd0, in_ready}, 32'd1);
         $display("reset cycle %0d valid=%0d ready=%0d", i, out_valid, in_ready);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      step();

      // First word after reset, then complete the operation
      xfer("r_w0", 32'd34, 32'd19, 1'b1, 32'd54, 1'b0, 1'b0);
      xfer("r_w1", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("r_w2", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("r_w3", 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);

      // 128-bit carry ripple
      xfer("rip_w0", 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("rip_w1", 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("rip_w2", 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("rip_w3", 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      in_valid = 1'b0;
      step();
      chk("rip_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure after word 1
      xfer("bp_w0", 32'hFFFFFFF0, 32'h20, 1'b0, 32'h10, 1'b0, 1'b0);
      xfer("bp_w1", 32'd1, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 32'hFFFFFFFF;
      in_b      = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_frozen", out_sum, 32'd4);
         $display("stall %0d in_ready=%0d sum=%08h", i, in_ready, out_sum);
      end
      // Release: drain of word 1 and accept of word 2 share one edge
      xfer("bp_w2", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
      xfer("bp_w3", 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'd0, 1'b1, 1'b1);
      in_valid = 1'b0;
      step();
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

      // Back-to-back operations, no carry leak
      xfer("bb0_w0", 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
      xfer("bb0_w1", 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
      xfer("bb0_w2", 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
      xfer("bb0_w3", 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
      xfer("bb1_w0", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("bb1_w1", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("bb1_w2", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      xfer("bb1_w3", 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      in_valid = 1'b0;
      step();

      // Reset in the middle of an operation
      xfer("mr_w0", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0);
      xfer("mr_w1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      chk("mr_async_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_async_sum", out_sum, 32'd0);
      step();
      #2 rst_n = 1'b1;
      step();
      xfer("mr_p0", 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);
      xfer("mr_p1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
      xfer("mr_p2", 32'd0, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0);
      xfer("mr_p3", 32'd2, 32'd3, 1'b0, 32'd5, 1'b1, 1'b0);
      in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
